// File: rtl/preset_digit_editor_pkg.sv
// Shared stopwatch definitions: editor states, digit positions and BCD clamp limits.
package preset_digit_editor_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EDIT   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [1:0] DIG_M10 = 2'd3;
  localparam logic [1:0] DIG_M1  = 2'd2;
  localparam logic [1:0] DIG_S10 = 2'd1;
  localparam logic [1:0] DIG_S1  = 2'd0;

  localparam logic [3:0] MAX_DIGIT = 4'd9;
  localparam logic [3:0] MAX_S10   = 4'd5;

  // Tens-of-seconds tops out at 5, every other position at 9.
  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [1:0] pos);
    logic [3:0] lim;
    lim = (pos == DIG_S10) ? MAX_S10 : MAX_DIGIT;
    return (d > lim) ? lim : d;
  endfunction

endpackage

// File: rtl/preset_digit_editor_rise_detect.sv
// Rising-edge pulse from a debounced button level: one history register plus an AND.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic rise
);

  logic btn_q;

  // Previous button level
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_q <= 1'b0;
    end else begin
      btn_q <= btn;
    end
  end

  assign rise = btn & ~btn_q;

endmodule

// File: rtl/preset_digit_editor.sv
// Four-digit MM:SS preset editor driven by the encoder digit and two buttons;
// commits the preset with a one-cycle strobe and drives a blink cue for the display.
module preset_digit_editor
  import preset_digit_editor_pkg::*;
#(
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  enc_digit,
  input  logic        edit_btn,
  input  logic        next_btn,
  output logic [15:0] work_bcd,
  output logic [15:0] preset_bcd,
  output logic        preset_valid,
  output logic [1:0]  sel_digit,
  output logic        editing,
  output logic        blink
);

  localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

  state_t           state_r;
  logic [3:0]       enc_prev_r;
  logic [CNT_W-1:0] blink_cnt_r;
  logic             edit_rise_s;
  logic             next_rise_s;
  logic             enc_chg_s;
  logic [15:0]      wr_bcd_s;

  rise_detect u_edit_rise (
    .clk   (clk),
    .reset (reset),
    .btn   (edit_btn),
    .rise  (edit_rise_s)
  );

  rise_detect u_next_rise (
    .clk   (clk),
    .reset (reset),
    .btn   (next_btn),
    .rise  (next_rise_s)
  );

  assign enc_chg_s = (enc_digit != enc_prev_r);

  // Working value with this cycle's encoder write applied to the selected digit
  always_comb begin
    wr_bcd_s = work_bcd;
    if (enc_chg_s) begin
      wr_bcd_s[{sel_digit, 2'b00} +: 4] = clamp_digit(enc_digit, sel_digit);
    end else begin
      wr_bcd_s = work_bcd;
    end
  end

  // Editor state machine with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      enc_prev_r   <= 4'd0;
      blink_cnt_r  <= '0;
      work_bcd     <= 16'h0000;
      preset_bcd   <= 16'h0000;
      preset_valid <= 1'b0;
      sel_digit    <= DIG_M10;
      editing      <= 1'b0;
      blink        <= 1'b0;
    end else begin
      enc_prev_r   <= enc_digit;
      preset_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          blink       <= 1'b0;
          blink_cnt_r <= '0;
          if (edit_rise_s) begin
            state_r   <= EDIT;
            editing   <= 1'b1;
            sel_digit <= DIG_M10;
            work_bcd  <= preset_bcd;
          end else begin
            editing   <= 1'b0;
          end
        end
        EDIT: begin
          if (edit_rise_s) begin
            // Abort wins over next and drops any concurrent encoder write.
            state_r     <= IDLE;
            editing     <= 1'b0;
            blink       <= 1'b0;
            blink_cnt_r <= '0;
            sel_digit   <= DIG_M10;
            work_bcd    <= preset_bcd;
          end else begin
            work_bcd <= wr_bcd_s;
            if (next_rise_s && (sel_digit == DIG_S1)) begin
              state_r      <= COMMIT;
              editing      <= 1'b0;
              blink        <= 1'b0;
              blink_cnt_r  <= '0;
              preset_bcd   <= wr_bcd_s;
              preset_valid <= 1'b1;
            end else begin
              if (next_rise_s) begin
                sel_digit <= sel_digit - 2'd1;
              end
              if (blink_cnt_r == CNT_LAST) begin
                blink_cnt_r <= '0;
                blink       <= ~blink;
              end else begin
                blink_cnt_r <= blink_cnt_r + CNT_W'(1);
              end
            end
          end
        end
        COMMIT: begin
          state_r     <= IDLE;
          sel_digit   <= DIG_M10;
          editing     <= 1'b0;
          blink       <= 1'b0;
          blink_cnt_r <= '0;
        end
        default: begin
          state_r     <= IDLE;
          sel_digit   <= DIG_M10;
          editing     <= 1'b0;
          blink       <= 1'b0;
          blink_cnt_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_preset_digit_editor.sv
// Scoreboard bench for preset_digit_editor: committed presets are queued when the
// final next press is driven and compared whenever preset_valid is seen.
module tb_preset_digit_editor;

  logic        clk;
  logic        reset;
  logic [3:0]  enc_digit;
  logic        edit_btn;
  logic        next_btn;
  logic [15:0] work_bcd;
  logic [15:0] preset_bcd;
  logic        preset_valid;
  logic [1:0]  sel_digit;
  logic        editing;
  logic        blink;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];
  logic prev_valid = 1'b0;

  preset_digit_editor #(.BLINK_DIV(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .enc_digit    (enc_digit),
    .edit_btn     (edit_btn),
    .next_btn     (next_btn),
    .work_bcd     (work_bcd),
    .preset_bcd   (preset_bcd),
    .preset_valid (preset_valid),
    .sel_digit    (sel_digit),
    .editing      (editing),
    .blink        (blink)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  // Strobe monitor: every preset_valid pulse must match the oldest queued preset.
  always @(negedge clk) begin
    if (!reset && preset_valid) begin
      if (prev_valid) check("strobe_width", 32'd2, 32'd1);
      if (exp_q.size() == 0) check("stray_strobe", {16'd0, preset_bcd}, 32'hFFFF_FFFF);
      else check("preset_strobe", {16'd0, preset_bcd}, {16'd0, exp_q.pop_front()});
    end
    prev_valid = preset_valid & ~reset;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_edit();
    edit_btn = 1'b1; tick(1);
    edit_btn = 1'b0; tick(1);
  endtask

  task automatic press_next();
    next_btn = 1'b1; tick(1);
    next_btn = 1'b0; tick(1);
  endtask

  task automatic set_enc(input logic [3:0] v);
    enc_digit = v; tick(1);
  endtask

  task automatic check_idle(input string tag, input logic [15:0] val);
    check({tag, "_editing"}, {31'd0, editing}, 32'd0);
    check({tag, "_blink"}, {31'd0, blink}, 32'd0);
    check({tag, "_work"}, {16'd0, work_bcd}, {16'd0, val});
    check({tag, "_preset"}, {16'd0, preset_bcd}, {16'd0, val});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; enc_digit = 4'd0; edit_btn = 1'b0; next_btn = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(1);
    check_idle("rst", 16'h0000);
    check("rst_valid", {31'd0, preset_valid}, 32'd0);
    check("rst_sel", {30'd0, sel_digit}, 32'd3);

    // Encoder activity in IDLE must be ignored.
    for (int i = 0; i < 100; i++) begin
      enc_digit = 4'($urandom_range(0, 15));
      tick(1);
    end
    enc_digit = 4'd0;
    tick(1);
    check_idle("idle_enc", 16'h0000);
    check("idle_sel", {30'd0, sel_digit}, 32'd3);

    // Full edit with s10 clamped from 7 to 5.
    press_edit();
    check("enter_editing", {31'd0, editing}, 32'd1);
    check("enter_sel", {30'd0, sel_digit}, 32'd3);
    set_enc(4'd1);
    check("wr_m10", {16'd0, work_bcd}, 32'h1000);
    press_next();
    check("sel_m1", {30'd0, sel_digit}, 32'd2);
    set_enc(4'd2); press_next();
    check("sel_s10", {30'd0, sel_digit}, 32'd1);
    set_enc(4'd7);
    check("clamp_s10", {16'd0, work_bcd}, 32'h1250);
    press_next();
    check("sel_s1", {30'd0, sel_digit}, 32'd0);
    set_enc(4'd4);
    exp_q.push_back(16'h1254);
    press_next();
    check_idle("commit1", 16'h1254);
    check("commit1_sel", {30'd0, sel_digit}, 32'd3);

    // Abort discards the edit and issues no strobe.
    press_edit();
    set_enc(4'd8);
    check("abort_wr", {16'd0, work_bcd}, 32'h8254);
    press_edit();
    check_idle("abort", 16'h1254);

    // Encoder write coincident with the committing next press.
    press_edit();
    press_next(); press_next(); press_next();
    check("at_s1", {30'd0, sel_digit}, 32'd0);
    exp_q.push_back(16'h1259);
    enc_digit = 4'd9; next_btn = 1'b1; tick(1);
    next_btn = 1'b0; tick(1);
    check_idle("commit2", 16'h1259);

    // Edit and next together at m1 abort; the concurrent encoder write is dropped.
    press_edit();
    press_next();
    check("at_m1", {30'd0, sel_digit}, 32'd2);
    enc_digit = 4'd3; edit_btn = 1'b1; next_btn = 1'b1; tick(1);
    edit_btn = 1'b0; next_btn = 1'b0; tick(1);
    check_idle("abort2", 16'h1259);

    // 4'hC at m1 clamps to 9, then reset mid-edit wipes everything.
    press_edit();
    press_next();
    set_enc(4'hC);
    check("clamp_m1", {16'd0, work_bcd}, 32'h1959);
    reset = 1'b1; tick(1);
    reset = 1'b0; tick(1);
    check_idle("mid_rst", 16'h0000);
    check("mid_rst_sel", {30'd0, sel_digit}, 32'd3);

    // Blink phase: toggles every 4 cycles in EDIT, cleared on leaving.
    edit_btn = 1'b1; tick(1);
    edit_btn = 1'b0;
    check("blink_entry", {31'd0, blink}, 32'd0);
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      check($sformatf("blink_k%0d", k), {31'd0, blink}, 32'((k / 4) % 2));
    end
    tick(1);
    edit_btn = 1'b1; tick(1);
    edit_btn = 1'b0;
    check("blink_exit", {31'd0, blink}, 32'd0);
    check("blink_exit_editing", {31'd0, editing}, 32'd0);
    tick(3);

    check("pending_presets", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/preset_digit_editor.md
# preset_digit_editor

Downstream consumer of the rotary-encoder decoder's 0–9 digit output. Lets the user set a four-digit MM:SS stopwatch preset one digit at a time. Buttons select edit mode and step between digit positions. The block commits the finished preset to the stopwatch core with a one-cycle strobe, and exposes the working value and a blink cue to the seven-segment display stage.

## Interface
Parameters:
- BLINK_DIV, default 25_000_000: number of clk cycles per blink half-period.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- enc_digit  in  4  encoder digit, expected 0–9, synchronous to clk.
- edit_btn  in  1  debounced level; a rising edge enters edit mode, or aborts if already editing.
- next_btn  in  1  debounced level; a rising edge advances to the next digit.
- work_bcd  out  16  working value {m10,m1,s10,s1}, shown on the display while editing.
- preset_bcd  out  16  last committed preset.
- preset_valid  out  1  one-cycle pulse when preset_bcd has just been updated.
- sel_digit  out  2  digit being edited: 3 = m10 … 0 = s1.
- editing  out  1  high in EDIT state.
- blink  out  1  blink phase for the selected digit; 0 when not editing.

## Operation
- Reset values: state IDLE; work_bcd, preset_bcd = 16'h0000; preset_valid = 0; sel_digit = 3; editing = 0; blink = 0; enc_prev and button history = 0.
- Button edges: rise = btn & ~btn_q, using a registered previous level.
- Encoder change: enc_chg = (enc_digit != enc_prev). enc_prev is updated every cycle in every state.
- Digit clamp: any value above 9 becomes 9. The s10 digit additionally clamps above 5 to 5.

States:
- IDLE
  - edit_btn rise → EDIT.
  - On entry to EDIT: sel_digit = 3, work_bcd = preset_bcd, blink counter cleared, blink = 0.
  - enc_chg is ignored.
- EDIT
  - enc_chg → the selected nibble of work_bcd is written with clamp(enc_digit).
  - next_btn rise with sel_digit > 0 → sel_digit decrements by 1.
  - next_btn rise with sel_digit = 0 → COMMIT.
  - edit_btn rise → abort to IDLE. work_bcd is restored to preset_bcd and no strobe is issued.
- COMMIT (lasts exactly one cycle)
  - preset_valid = 1.
  - Then IDLE, with sel_digit = 3.

Simultaneous events:
- edit_btn rise and next_btn rise in the same cycle: abort wins, next is ignored.
- enc_chg and next_btn rise in the same cycle: the write goes to the current sel_digit, then sel_digit advances.
- enc_chg and the commit-triggering next_btn rise: the write is included in the committed value.
- enc_chg and edit_btn rise (abort): the write is discarded.

Blink:
- Counter runs only in EDIT and counts 0..BLINK_DIV−1.
- blink toggles when the counter wraps.
- blink is forced to 0 outside EDIT.

Reset mid-edit returns to the reset values and discards both the working value and the committed value.

## Timing
- All outputs are registered.
- enc_digit change at edge N is seen by enc_prev at edge N. work_bcd updates at edge N+1, so latency is 1 cycle after enc_digit is sampled.
- Button rising level sampled at edge N → state and sel_digit update at edge N+1 (1-cycle latency).
- Commit sequence:
  - At the edge that enters COMMIT, preset_bcd is loaded with the final work_bcd, including any simultaneous write.
  - preset_valid is high for exactly the following cycle.
  - preset_valid and the new preset_bcd are therefore coincident.
- Blink half-period is exactly BLINK_DIV cycles. The first toggle occurs BLINK_DIV cycles after entering EDIT.
- No back-pressure: the consumer must accept preset_valid in the cycle it is asserted.

## Structure
Shared stopwatch package holds:
- State typedef: IDLE, EDIT, COMMIT.
- Digit index constants: DIG_M10=3, DIG_M1=2, DIG_S10=1, DIG_S1=0.
- Clamp limits: MAX_DIGIT=9, MAX_S10=5.

Sub-module rise_detect: one register plus AND, rising-edge pulse. Instantiated for edit_btn and next_btn.

## Test plan
- Reset, then idle 100 cycles with enc_digit toggling → all outputs at reset values; preset_valid never pulses.
- Edit_btn rise; set enc 1, next; 2, next; 7, next; 4, next → preset_bcd = 16'h1254 (s10 clamped from 7 to 5). preset_valid is one pulse, coincident with the new preset_bcd. sel_digit returns to 3.
- Re-enter edit, write m10 = 8, then edit_btn rise → IDLE; work_bcd and preset_bcd remain 16'h1254; no strobe.
- During EDIT at sel_digit = 0: enc change to 9 in the same cycle as next_btn rise → preset_bcd[3:0] = 9 and preset_valid pulses. Separately, edit and next rise together at sel_digit = 2 → abort.
- enc_digit = 4'hC written at the m1 position → nibble = 9. Reset asserted mid-edit → state IDLE and preset_bcd = 0.
- BLINK_DIV = 4 → blink toggles every 4 cycles in EDIT and is 0 within 1 cycle of leaving EDIT.
